// File: rtl/timer16.sv
// rtl/timer16.sv - memory-mapped 16-bit timer/counter with prescaler and compare match
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   din      in   [7:0] bus write data
//   address  in   [7:0] bus address (TIMER_ADDRESS+0 .. +5 decoded)
//   w_en     in   bus write strobe
//   r_en     in   bus read strobe
//   dout     out  [7:0] registered read data
//   irq      out  one-cycle interrupt pulse
module timer16 #(
  parameter logic [7:0] TIMER_ADDRESS = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       irq
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  ctrl_q, ctrl_d;      // [0] EN, [1] IRQ_EN, [2] ONESHOT, [5:3] PRESC
  logic        match_q, match_d;
  logic [15:0] cmp_q, cmp_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  cnth_q, cnth_d;
  logic [6:0]  presc_q, presc_d;
  logic [7:0]  dout_q, dout_d;
  logic        irq_q, irq_d;

  logic [7:0]  offset;
  logic        hit;
  logic        wr_ctrl, wr_stat, wr_cmpl, wr_cmph, wr_cnt;
  logic [6:0]  presc_top;
  logic        running, tick, match_evt;

  assign offset  = address - TIMER_ADDRESS;
  assign hit     = (offset < 8'd6);
  assign wr_ctrl = w_en && hit && (offset == 8'd0);
  assign wr_stat = w_en && hit && (offset == 8'd1);
  assign wr_cmpl = w_en && hit && (offset == 8'd2);
  assign wr_cmph = w_en && hit && (offset == 8'd3);
  assign wr_cnt  = w_en && hit && ((offset == 8'd4) || (offset == 8'd5));

  // (1 << PRESC) - 1 expressed as a right shift of all-ones
  assign presc_top = 7'h7F >> (3'd7 - ctrl_q[5:3]);

  // Counting stops as soon as EN drops, even during the RUN->IDLE cycle,
  // so a one-shot leaves count at 0.
  assign running   = (state_q == RUN) && ctrl_q[0];
  assign tick      = running && (presc_q == presc_top);
  // A counter write swallows the tick entirely, including its compare.
  assign match_evt = tick && !wr_cnt && (count_q == cmp_q);

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    match_d = match_q;
    cmp_d   = cmp_q;
    count_d = count_q;
    cnth_d  = cnth_q;
    presc_d = presc_q;
    dout_d  = 8'h00;
    irq_d   = match_evt && ctrl_q[1];

    case (state_q)
      IDLE:    if (ctrl_q[0])  state_d = RUN;
      RUN:     if (!ctrl_q[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || wr_cnt) begin
      presc_d = 7'd0;
    end else if (running) begin
      presc_d = tick ? 7'd0 : presc_q + 7'd1;
    end

    if (wr_cnt) begin
      count_d = 16'd0;
    end else if (tick) begin
      count_d = match_evt ? 16'd0 : count_q + 16'd1;
    end

    // Hardware one-shot clear first so a same-cycle software write overrides it.
    if (match_evt && ctrl_q[2]) ctrl_d[0] = 1'b0;
    if (wr_ctrl) ctrl_d = din[5:0];

    // Set beats write-1-clear.
    if (wr_stat && din[0]) match_d = 1'b0;
    if (match_evt) match_d = 1'b1;

    if (wr_cmpl) cmp_d[7:0]  = din;
    if (wr_cmph) cmp_d[15:8] = din;

    // Reads use current register values, so a same-cycle write is not visible.
    if (r_en && hit) begin
      case (offset)
        8'd0: dout_d = {2'b00, ctrl_q};
        8'd1: dout_d = {7'd0, match_q};
        8'd2: dout_d = cmp_q[7:0];
        8'd3: dout_d = cmp_q[15:8];
        8'd4: begin
          dout_d = count_q[7:0];
          cnth_d = count_q[15:8];
        end
        8'd5: dout_d = cnth_q;
        default: dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= 6'd0;
      match_q <= 1'b0;
      cmp_q   <= 16'd0;
      count_q <= 16'd0;
      cnth_q  <= 8'd0;
      presc_q <= 7'd0;
      dout_q  <= 8'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
      cmp_q   <= cmp_d;
      count_q <= count_d;
      cnth_q  <= cnth_d;
      presc_q <= presc_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule
